// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_FINISH
  } spi_master_state_t;

  localparam int SPI_FRAME_BYTES_32x32 = 1024;
  localparam int SPI_MIN_CLK_DIV       = 4;

endpackage

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module spi_half_period_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // Loading N-1 on state entry keeps the state for exactly N cycles.
  assign tc = (count == '0);

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 master streaming one full frame of bytes with SS held low throughout.
module spi_frame_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV     = 8,
  parameter int FRAME_BYTES = SPI_FRAME_BYTES_32x32,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = $clog2(FRAME_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              abort,
  input  logic [7:0]        pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_ss,
  output logic              busy,
  output logic [CNT_W-1:0]  byte_count,
  output logic [7:0]        miso_byte,
  output logic              frame_done,
  output spi_master_state_t dbg_state
);

  // Handshake: a byte moves on a rising clk edge where pix_valid && pix_ready;
  // pix_data must be stable while pix_valid is high, pix_ready only in LOAD.

  localparam int TW = 16;
  localparam logic [TW-1:0] LD_HALF = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] LD_GAP  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  spi_master_state_t state;
  logic [7:0]        tx_sr;
  logic [7:0]        rx_sr;
  logic [2:0]        bit_idx;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_tc;
  logic              last_byte;

  assign last_byte = (byte_count == CNT_W'(FRAME_BYTES - 1));

  // The timer reloads on every state or SCLK phase change, so it never wraps across states.
  always_comb begin
    tmr_load = (state == ST_IDLE) || (state == ST_LOAD) || tmr_tc;
    tmr_val  = LD_HALF;
    if (state == ST_SHIFT && spi_sclk && bit_idx == 3'd7 && !last_byte) begin
      tmr_val = LD_GAP;
    end
  end

  spi_half_period_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      spi_ss     <= 1'b1;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      byte_count <= '0;
      miso_byte  <= 8'h00;
      frame_done <= 1'b0;
      tx_sr      <= 8'h00;
      rx_sr      <= 8'h00;
      bit_idx    <= 3'd0;
    end else begin
      frame_done <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state    <= ST_IDLE;
        spi_ss   <= 1'b1;
        spi_sclk <= 1'b0;
        spi_mosi <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (frame_start && !abort) begin
              state      <= ST_SETUP;
              spi_ss     <= 1'b0;
              byte_count <= '0;
            end
          end
          ST_SETUP: begin
            if (tmr_tc) state <= ST_LOAD;
          end
          ST_LOAD: begin
            if (pix_valid) begin
              tx_sr    <= pix_data;
              spi_mosi <= pix_data[7];
              bit_idx  <= 3'd0;
              state    <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (tmr_tc) begin
              if (!spi_sclk) begin
                spi_sclk <= 1'b1;
                rx_sr    <= {rx_sr[6:0], spi_miso};
              end else begin
                spi_sclk <= 1'b0;
                if (bit_idx == 3'd7) begin
                  byte_count <= byte_count + CNT_W'(1);
                  miso_byte  <= rx_sr;
                  if (last_byte)            state <= ST_FINISH;
                  else if (GAP_CYCLES == 0) state <= ST_LOAD;
                  else                      state <= ST_GAP;
                end else begin
                  bit_idx  <= bit_idx + 3'd1;
                  spi_mosi <= tx_sr[6];
                  tx_sr    <= {tx_sr[6:0], 1'b0};
                end
              end
            end
          end
          ST_GAP: begin
            if (tmr_tc) state <= ST_LOAD;
          end
          ST_FINISH: begin
            if (tmr_tc) begin
              spi_ss     <= 1'b1;
              spi_mosi   <= 1'b0;
              frame_done <= 1'b1;
              state      <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Gating with abort keeps a byte from being consumed on the cycle the frame is killed.
  assign pix_ready = (state == ST_LOAD) && !abort;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule
